// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a small receive FIFO and a register
// interface for the CPU. It samples the rx pin through a two-flop
// synchroniser, recovers bytes with a divider-paced FSM, and buffers them
// until they are read. Overrun and framing conditions are kept as sticky,
// write-1-to-clear flags. irq stays high while received data is pending.

module uart_rx #(
  parameter int unsigned DIVIDER    = 7,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] addr,
  input  logic       ren,
  output logic [7:0] rdata,
  output logic       rd_valid,
  input  logic       wen,
  input  logic [7:0] wdata,
  input  logic       rx,
  output logic       irq
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  localparam logic [12:0] DivFull = 13'(DIVIDER);
  localparam logic [12:0] DivHalf = 13'(DIVIDER / 2);

  localparam logic [4:0] AddrData   = 5'h00;
  localparam logic [4:0] AddrStatus = 5'h04;

  localparam logic [DEPTH_LOG2:0] CountFull = (DEPTH_LOG2 + 1)'(Depth);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  // Input synchroniser
  logic rx_meta;
  logic rx_s;

  // Receive FSM state
  state_e      state;
  logic [12:0] div;
  logic [2:0]  bitcnt;
  logic [7:0]  shreg;

  // FIFO storage and bookkeeping
  logic [7:0]            mem [Depth];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_next;

  // Sticky flags
  logic overrun;
  logic framing;

  // Decoded strobes and events
  logic tick;
  logic push_valid;
  logic frame_err;
  logic data_rd;
  logic stat_rd;
  logic stat_wr;
  logic fifo_empty;
  logic fifo_full;
  logic do_push;
  logic do_pop;
  logic ovr_set;
  logic ovr_clr;
  logic frm_clr;

  // Only bits 1 and 2 of a STATUS write carry meaning.
  logic unused_wdata;
  assign unused_wdata = ^{wdata[7:3], wdata[0]};

  // Two-flop synchroniser, idles high so reset looks like a quiet line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick = (div == 13'd0);

  // The stop sample decides the fate of the assembled byte in this cycle.
  assign push_valid = (state == StStop) && tick && rx_s;
  assign frame_err  = (state == StStop) && tick && !rx_s;

  // Receive FSM: one shared down-counter paces start, data and stop samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= StIdle;
      div    <= 13'd0;
      bitcnt <= 3'd0;
      shreg  <= 8'h00;
    end else begin
      case (state)
        StIdle: begin
          if (!rx_s) begin
            state <= StStart;
            div   <= DivHalf;
          end
        end
        StStart: begin
          if (tick) begin
            div <= DivFull;
            if (!rx_s) begin
              state  <= StData;
              bitcnt <= 3'd0;
            end else begin
              // Start bit vanished before mid-bit: treat as noise.
              state <= StIdle;
            end
          end else begin
            div <= div - 13'd1;
          end
        end
        StData: begin
          if (tick) begin
            div    <= DivFull;
            shreg  <= {rx_s, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              state <= StStop;
            end
          end else begin
            div <= div - 13'd1;
          end
        end
        StStop: begin
          if (tick) begin
            div   <= DivFull;
            state <= rx_s ? StIdle : StBreak;
          end else begin
            div <= div - 13'd1;
          end
        end
        StBreak: begin
          // Wait out a held-low line before hunting for the next start bit.
          if (rx_s) begin
            state <= StIdle;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  assign data_rd = ren && (addr == AddrData);
  assign stat_rd = ren && (addr == AddrStatus);
  assign stat_wr = wen && (addr == AddrStatus);

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CountFull);

  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // still accepted then; popping an empty FIFO is a no-op.
  assign do_pop  = data_rd && !fifo_empty;
  assign do_push = push_valid && (!fifo_full || do_pop);
  assign ovr_set = push_valid && fifo_full && !do_pop;

  assign ovr_clr = stat_wr && wdata[1];
  assign frm_clr = stat_wr && wdata[2];

  // Next occupancy, shared by the FIFO counter and the interrupt register.
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // FIFO pointers, occupancy and storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      count <= count_next;
      if (do_push) begin
        mem[wptr] <= shreg;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  // Sticky flags: a set in the same cycle as its clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
      framing <= 1'b0;
    end else begin
      overrun <= (overrun && !ovr_clr) || ovr_set;
      framing <= (framing && !frm_clr) || frame_err;
    end
  end

  // Registered read port; rdata holds between reads of mapped registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata    <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= data_rd || stat_rd;
      if (data_rd) begin
        rdata <= fifo_empty ? 8'h00 : mem[rptr];
      end else if (stat_rd) begin
        rdata <= {4'b0000, fifo_full, framing, overrun, !fifo_empty};
      end
    end
  end

  // Interrupt follows the occupancy being committed at this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= (count_next != '0);
    end
  end

endmodule
